wb_rr_manager_arbiter: RTL and testbench

- Round-robin Wishbone arbiter sharing the single peripheral-side bus (in front of the address decoder) among NUM_MANAGERS managers, e.g. the mgmt SoC port plus on-chip DMA/test managers.
- Grants bus ownership per CYC cycle, muxes the owner's request signals onto the shared bus, and routes ACK/data back to the owner only.
- Optional watchdog aborts transfers whose peripheral never acknowledges, so the bus cannot hang.

---
 rtl/wb_rr_manager_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_wb_rr_manager_arbiter.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_manager_arbiter.sv
// wb_rr_manager_arbiter
//
// Round-robin arbiter that shares the single peripheral-side Wishbone bus
// among NUM_MANAGERS managers. Ownership is granted for a whole CYC cycle.
// The owner's request is muxed onto the shared bus, and ACK/read data are
// routed back to the owner only.
//
// Build option WB_ARB_TIMEOUT_EN adds a watchdog that counts consecutive
// STB-without-ACK cycles. At TIMEOUT_CYCLES it aborts the transfer with a
// one-cycle A_ERR_O pulse and parks the bus in DRAIN until the owner releases
// CYC. Without the macro, A_ERR_O is tied low. A silent peripheral then
// holds the bus until the owner drops CYC.
//
// state | meaning
// IDLE  | no owner; pick the first CYC&STB requester after the last owner
// OWN   | owner's request drives the shared bus; ACK/DAT routed to owner
// DRAIN | watchdog fired; shared bus idle until owner drops CYC
//         (only with WB_ARB_TIMEOUT_EN)

module wb_rr_manager_arbiter #(
    parameter int NUM_MANAGERS   = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic                         CLK,
    input  logic                         nRST,

    input  logic [32*NUM_MANAGERS-1:0]   A_ADR_I,
    input  logic [32*NUM_MANAGERS-1:0]   A_DAT_I,
    input  logic [4*NUM_MANAGERS-1:0]    A_SEL_I,
    input  logic [NUM_MANAGERS-1:0]      A_WE_I,
    input  logic [NUM_MANAGERS-1:0]      A_STB_I,
    input  logic [NUM_MANAGERS-1:0]      A_CYC_I,
    output logic [32*NUM_MANAGERS-1:0]   A_DAT_O,
    output logic [NUM_MANAGERS-1:0]      A_ACK_O,
    output logic [NUM_MANAGERS-1:0]      A_ERR_O,

    input  logic [31:0]                  DAT_I,
    input  logic                         ACK_I,
    output logic [31:0]                  ADR_O,
    output logic [31:0]                  DAT_O,
    output logic [3:0]                   SEL_O,
    output logic                         WE_O,
    output logic                         STB_O,
    output logic                         CYC_O,

    output logic [NUM_MANAGERS-1:0]      GNT_O
);

    localparam int IDX_W = $clog2(NUM_MANAGERS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_MANAGERS-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;

    logic [NUM_MANAGERS-1:0] req;
    logic                    win_found;
    logic [IDX_W-1:0]        win_idx;

    logic                    own_cyc;
    logic                    own_stb;
    logic                    expire;

    // Bit offsets of the owner's lanes inside the packed manager buses.
    logic [IDX_W+4:0]        own_word_lsb;
    logic [IDX_W+1:0]        own_sel_lsb;

    assign req          = A_CYC_I & A_STB_I;
    assign own_cyc      = A_CYC_I[owner_q];
    assign own_stb      = own_cyc & A_STB_I[owner_q];
    assign own_word_lsb = {owner_q, 5'd0};
    assign own_sel_lsb  = {owner_q, 2'd0};

    // Round-robin search: first requester after the last owner, wrapping.
    always_comb begin
        int               k;
        logic [IDX_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        k         = 0;
        cand      = '0;
        for (int i = 1; i <= NUM_MANAGERS; i++) begin
            k    = (int'(ptr_q) + i) % NUM_MANAGERS;
            cand = IDX_W'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [TO_W-1:0] wd_q, wd_d;
    logic            stall;

    // A stall is an owner strobe that the peripheral left unanswered this cycle.
    assign stall  = (state_q == ST_OWN) & own_stb & ~ACK_I;
    assign expire = stall & (wd_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog next value: count consecutive stalls; any ACK, idle strobe,
    // expiry or loss of ownership restarts it.
    always_comb begin
        wd_d = '0;
        if (stall && !expire) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Watchdog register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign expire             = 1'b0;
    assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, TO_W};
`endif

    // FSM state register together with grant, owner and round-robin pointer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= IDX_W'(NUM_MANAGERS - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // FSM next-state: grant in IDLE, hold while owner keeps CYC, release on drop.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d        = ST_OWN;
                    owner_d        = win_idx;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                end
            end
            ST_OWN: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    ptr_d   = owner_q;
                    gnt_d   = '0;
                end else if (expire) begin
                    state_d = ST_DRAIN;
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            ST_DRAIN: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    ptr_d   = owner_q;
                    gnt_d   = '0;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // FSM outputs: shared bus and return paths are live only while in OWN.
    // An expiring cycle still routes ACK_I back, but ACK_I is 0 by definition then.
    always_comb begin
        CYC_O   = 1'b0;
        STB_O   = 1'b0;
        WE_O    = 1'b0;
        ADR_O   = '0;
        DAT_O   = '0;
        SEL_O   = '0;
        A_ACK_O = '0;
        A_ERR_O = '0;
        A_DAT_O = '0;
        if (state_q == ST_OWN) begin
            CYC_O                       = own_cyc & ~expire;
            STB_O                       = own_stb & ~expire;
            WE_O                        = A_WE_I[owner_q];
            ADR_O                       = A_ADR_I[own_word_lsb +: 32];
            DAT_O                       = A_DAT_I[own_word_lsb +: 32];
            SEL_O                       = A_SEL_I[own_sel_lsb +: 4];
            A_ACK_O[owner_q]            = ACK_I;
            A_ERR_O[owner_q]            = expire;
            A_DAT_O[own_word_lsb +: 32] = DAT_I;
        end
    end

    assign GNT_O = gnt_q;

endmodule

// File: tb/tb_wb_rr_manager_arbiter.sv
// Bench for wb_rr_manager_arbiter: directed scenarios plus a randomized run,
// all checked against a cycle-level behavioural model of the arbiter rules.
module tb_wb_rr_manager_arbiter;

    localparam int N   = 3;
    localparam int TMO = 4;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            nRST = 1'b0;
    logic [32*N-1:0] a_adr = '0;
    logic [32*N-1:0] a_dat = '0;
    logic [4*N-1:0]  a_sel = '0;
    logic [N-1:0]    a_we  = '0;
    logic [N-1:0]    a_stb = '0;
    logic [N-1:0]    a_cyc = '0;
    logic [32*N-1:0] A_DAT_O;
    logic [N-1:0]    A_ACK_O;
    logic [N-1:0]    A_ERR_O;
    logic [31:0]     dat_i = '0;
    logic            ack_i = 1'b0;
    logic [31:0]     ADR_O, DAT_O;
    logic [3:0]      SEL_O;
    logic            WE_O, STB_O, CYC_O;
    logic [N-1:0]    GNT_O;

    int cmps = 0;
    int errs = 0;

    wb_rr_manager_arbiter #(
        .NUM_MANAGERS   (N),
        .TIMEOUT_CYCLES (TMO),
        .TO_W           (8)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .A_ADR_I (a_adr),
        .A_DAT_I (a_dat),
        .A_SEL_I (a_sel),
        .A_WE_I  (a_we),
        .A_STB_I (a_stb),
        .A_CYC_I (a_cyc),
        .A_DAT_O (A_DAT_O),
        .A_ACK_O (A_ACK_O),
        .A_ERR_O (A_ERR_O),
        .DAT_I   (dat_i),
        .ACK_I   (ack_i),
        .ADR_O   (ADR_O),
        .DAT_O   (DAT_O),
        .SEL_O   (SEL_O),
        .WE_O    (WE_O),
        .STB_O   (STB_O),
        .CYC_O   (CYC_O),
        .GNT_O   (GNT_O)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    int           m_own;      // -1 = nobody owns the bus
    int           m_ptr;      // last owner
    int           m_stall;    // consecutive unanswered strobe cycles
    bit           m_drain;
    bit           m_expire;
    bit           m_stb_raw;
    logic [N-1:0] m_gnt;

    logic         e_cyc, e_stb, e_we;
    logic [31:0]  e_adr, e_dat;
    logic [3:0]   e_sel;
    logic [N-1:0] e_ack, e_err;
    logic [32*N-1:0] e_adat;

    task automatic model_reset();
        m_own   = -1;
        m_ptr   = N - 1;
        m_stall = 0;
        m_drain = 1'b0;
        m_gnt   = '0;
    endtask

    task automatic model_comb();
        e_cyc = 0; e_stb = 0; e_we = 0; e_adr = '0; e_dat = '0; e_sel = '0;
        e_ack = '0; e_err = '0; e_adat = '0;
        m_expire = 1'b0; m_stb_raw = 1'b0;
        if (m_own >= 0 && !m_drain) begin
            e_cyc     = a_cyc[m_own];
            m_stb_raw = a_cyc[m_own] & a_stb[m_own];
            e_stb     = m_stb_raw;
            if (TO_EN && m_stb_raw && !ack_i && (m_stall + 1 == TMO))
                m_expire = 1'b1;
            if (m_expire) begin
                e_cyc = 1'b0;
                e_stb = 1'b0;
                e_err[m_own] = 1'b1;
            end
            e_we  = a_we[m_own];
            e_adr = a_adr[32*m_own +: 32];
            e_dat = a_dat[32*m_own +: 32];
            e_sel = a_sel[4*m_own +: 4];
            e_ack[m_own] = ack_i;
            e_adat[32*m_own +: 32] = dat_i;
        end
    endtask

    task automatic model_seq();
        bit found;
        int k;
        found = 1'b0;
        if (m_own < 0) begin
            for (int i = 1; i <= N; i++) begin
                k = (m_ptr + i) % N;
                if (!found && a_cyc[k] && a_stb[k]) begin
                    found = 1'b1;
                    m_own = k;
                    m_gnt = '0;
                    m_gnt[k] = 1'b1;
                    m_stall = 0;
                end
            end
        end else if (!a_cyc[m_own]) begin
            m_ptr   = m_own;
            m_own   = -1;
            m_gnt   = '0;
            m_drain = 1'b0;
            m_stall = 0;
        end else if (!m_drain) begin
            if (m_expire) begin
                m_drain = 1'b1;
                m_stall = 0;
            end else if (m_stb_raw && !ack_i) begin
                m_stall++;
            end else begin
                m_stall = 0;
            end
        end
    endtask

    // Sample point: mid-cycle, inputs stable, model outputs evaluated.
    task automatic sample();
        @(negedge CLK);
        model_comb();
    endtask

    task automatic advance();
        model_seq();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_all();
        a_cyc = '0; a_stb = '0; ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            advance();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        model_reset();
        nRST  = 1'b0;
        a_cyc = 3'b011; a_stb = 3'b011; ack_i = 1'b1; dat_i = 32'hCAFE_F00D;
        a_adr = {32'h3, 32'h2, 32'h1};
        repeat (2) @(negedge CLK);
        cmps++;
        if (GNT_O !== '0) begin errs++; $display("FAIL reset_gnt: got %b expected 000", GNT_O); end
        cmps++;
        if ({CYC_O, STB_O, WE_O, SEL_O, ADR_O, DAT_O} !== '0) begin
            errs++; $display("FAIL reset_bus: got %b/%b/%h expected 0", CYC_O, STB_O, ADR_O);
        end
        cmps++;
        if ({A_ACK_O, A_ERR_O, A_DAT_O} !== '0) begin
            errs++; $display("FAIL reset_mgr: got ack %b err %b dat %h expected 0", A_ACK_O, A_ERR_O, A_DAT_O);
        end
        a_cyc = '0; a_stb = '0; ack_i = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
    endtask

    task automatic test_simultaneous();
        a_adr = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
        a_cyc = 3'b011; a_stb = 3'b011; ack_i = 1'b0;
        sample();
        cmps++;
        if (GNT_O !== 3'b000) begin errs++; $display("FAIL sim_latency: got %b expected 000", GNT_O); end
        advance();
        sample();
        cmps++;
        if (GNT_O !== 3'b001) begin errs++; $display("FAIL sim_gnt: got %b expected 001", GNT_O); end
        cmps++;
        if (ADR_O !== 32'h1000_0000) begin errs++; $display("FAIL sim_adr: got %h expected 10000000", ADR_O); end
        cmps++;
        if (A_ACK_O !== 3'b000) begin errs++; $display("FAIL sim_noack: got %b expected 000", A_ACK_O); end
        advance();
        ack_i = 1'b1; dat_i = 32'h1234_5678;
        sample();
        cmps++;
        if (A_ACK_O !== 3'b001) begin errs++; $display("FAIL sim_ack: got %b expected 001", A_ACK_O); end
        cmps++;
        if (A_DAT_O !== {64'h0, 32'h1234_5678}) begin
            errs++; $display("FAIL sim_rdat: got %h expected %h", A_DAT_O, {64'h0, 32'h1234_5678});
        end
        advance();
    endtask

    task automatic test_alternation();
        ack_i = 1'b0;
        a_cyc = 3'b010; a_stb = 3'b010;
        sample();
        cmps++;
        if ({CYC_O, STB_O} !== 2'b00) begin errs++; $display("FAIL alt_drop: got %b expected 00", {CYC_O, STB_O}); end
        advance();
        a_cyc = 3'b011; a_stb = 3'b011;
        sample();
        cmps++;
        if (GNT_O !== 3'b000) begin errs++; $display("FAIL alt_idle1: got %b expected 000", GNT_O); end
        advance();
        sample();
        cmps++;
        if (GNT_O !== 3'b010) begin errs++; $display("FAIL alt_gnt1: got %b expected 010", GNT_O); end
        cmps++;
        if (ADR_O !== 32'h2000_0000) begin errs++; $display("FAIL alt_adr1: got %h expected 20000000", ADR_O); end
        advance();
        a_cyc = 3'b001; a_stb = 3'b001;
        sample();
        advance();
        a_cyc = 3'b011; a_stb = 3'b011;
        sample();
        cmps++;
        if (GNT_O !== 3'b000) begin errs++; $display("FAIL alt_idle2: got %b expected 000", GNT_O); end
        advance();
        sample();
        cmps++;
        if (GNT_O !== 3'b001) begin errs++; $display("FAIL alt_gnt0: got %b expected 001", GNT_O); end
        advance();
    endtask

    task automatic test_burst();
        for (int b = 0; b < 4; b++) begin
            ack_i = 1'b0;
            sample();
            cmps++;
            if ({GNT_O, A_ACK_O} !== {3'b001, 3'b000}) begin
                errs++; $display("FAIL burst_wait%0d: got gnt %b ack %b expected 001/000", b, GNT_O, A_ACK_O);
            end
            advance();
            ack_i = 1'b1; dat_i = $urandom;
            sample();
            cmps++;
            if ({GNT_O, A_ACK_O} !== {3'b001, 3'b001}) begin
                errs++; $display("FAIL burst_beat%0d: got gnt %b ack %b expected 001/001", b, GNT_O, A_ACK_O);
            end
            advance();
        end
        ack_i = 1'b0;
        a_cyc = 3'b010; a_stb = 3'b010;
        sample();
        advance();
        sample();
        advance();
        sample();
        cmps++;
        if ({GNT_O, A_ACK_O} !== {3'b010, 3'b000}) begin
            errs++; $display("FAIL burst_handover: got gnt %b ack %b expected 010/000", GNT_O, A_ACK_O);
        end
        advance();
    endtask

    task automatic test_read();
        ack_i = 1'b1; dat_i = 32'hDEAD_BEEF;
        sample();
        cmps++;
        if (A_DAT_O[63:32] !== 32'hDEAD_BEEF) begin errs++; $display("FAIL read_hi: got %h expected deadbeef", A_DAT_O[63:32]); end
        cmps++;
        if ({A_DAT_O[95:64], A_DAT_O[31:0]} !== 64'h0) begin
            errs++; $display("FAIL read_others: got %h expected 0", {A_DAT_O[95:64], A_DAT_O[31:0]});
        end
        cmps++;
        if (A_ACK_O !== 3'b010) begin errs++; $display("FAIL read_ack: got %b expected 010", A_ACK_O); end
        advance();
        idle_all();
    endtask

    task automatic test_timeout();
`ifdef WB_ARB_TIMEOUT_EN
        a_cyc = 3'b100; a_stb = 3'b100; ack_i = 1'b0;
        sample();
        advance();
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) begin a_cyc = 3'b101; a_stb = 3'b101; end
            sample();
            if (c < 4) begin
                cmps++;
                if ({STB_O, A_ERR_O} !== {1'b1, 3'b000}) begin
                    errs++; $display("FAIL to_stall%0d: got stb %b err %b expected 1/000", c, STB_O, A_ERR_O);
                end
            end else begin
                cmps++;
                if ({CYC_O, STB_O, A_ERR_O} !== {2'b00, 3'b100}) begin
                    errs++; $display("FAIL to_expire: got cyc %b stb %b err %b expected 0/0/100", CYC_O, STB_O, A_ERR_O);
                end
            end
            advance();
        end
        ack_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample();
            cmps++;
            if ({CYC_O, STB_O, A_ACK_O, A_ERR_O, GNT_O[1:0]} !== '0) begin
                errs++; $display("FAIL to_drain%0d: got cyc %b stb %b ack %b err %b gnt %b expected all 0 and no new grant",
                                 c, CYC_O, STB_O, A_ACK_O, A_ERR_O, GNT_O);
            end
            advance();
        end
        ack_i = 1'b0;
        a_cyc = 3'b001; a_stb = 3'b001;
        sample();
        advance();
        sample();
        advance();
        sample();
        cmps++;
        if (GNT_O !== 3'b001) begin errs++; $display("FAIL to_after: got %b expected 001", GNT_O); end
        advance();
        idle_all();
        a_cyc = 3'b010; a_stb = 3'b010;
        sample();
        advance();
        for (int c = 1; c <= 7; c++) begin
            ack_i = (c == 4);
            sample();
            cmps++;
            if ({STB_O, A_ERR_O, A_ACK_O} !== {1'b1, 3'b000, (c == 4) ? 3'b010 : 3'b000}) begin
                errs++; $display("FAIL to_ackwin%0d: got stb %b err %b ack %b", c, STB_O, A_ERR_O, A_ACK_O);
            end
            advance();
        end
        idle_all();
`else
        a_cyc = 3'b010; a_stb = 3'b010; ack_i = 1'b0;
        sample();
        advance();
        for (int c = 1; c <= 11; c++) begin
            ack_i = (c == 11);
            sample();
            cmps++;
            if ({CYC_O, STB_O, A_ERR_O, A_ACK_O} !== {2'b11, 3'b000, (c == 11) ? 3'b010 : 3'b000}) begin
                errs++; $display("FAIL nowd_hold%0d: got cyc %b stb %b err %b ack %b", c, CYC_O, STB_O, A_ERR_O, A_ACK_O);
            end
            advance();
        end
        idle_all();
`endif
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (a_cyc[k]) begin
                    if ($urandom_range(7) == 0) begin
                        a_cyc[k] = 1'b0; a_stb[k] = 1'b0;
                    end else begin
                        a_stb[k] = ($urandom_range(3) != 0);
                    end
                end else if ($urandom_range(5) == 0) begin
                    a_cyc[k] = 1'b1; a_stb[k] = 1'b1;
                end
                a_we[k] = $urandom_range(1);
            end
            for (int k = 0; k < N; k++) begin
                a_adr[32*k +: 32] = $urandom;
                a_dat[32*k +: 32] = $urandom;
            end
            a_sel = 12'($urandom);
            ack_i = ($urandom_range(2) == 0);
            dat_i = $urandom;
            sample();
            cmps++;
            if ({CYC_O, STB_O, WE_O, SEL_O, ADR_O, DAT_O} !== {e_cyc, e_stb, e_we, e_sel, e_adr, e_dat}) begin
                errs++; $display("FAIL rnd_bus@%0d: got %b%b%b %h %h %h expected %b%b%b %h %h %h", cyc,
                                 CYC_O, STB_O, WE_O, SEL_O, ADR_O, DAT_O, e_cyc, e_stb, e_we, e_sel, e_adr, e_dat);
            end
            cmps++;
            if ({GNT_O, A_ACK_O, A_ERR_O} !== {m_gnt, e_ack, e_err}) begin
                errs++; $display("FAIL rnd_ctl@%0d: got gnt %b ack %b err %b expected %b %b %b", cyc,
                                 GNT_O, A_ACK_O, A_ERR_O, m_gnt, e_ack, e_err);
            end
            cmps++;
            if (A_DAT_O !== e_adat) begin
                errs++; $display("FAIL rnd_rdat@%0d: got %h expected %h", cyc, A_DAT_O, e_adat);
            end
            advance();
        end
        a_we = '0; a_sel = '0;
        idle_all();
    endtask

    task automatic test_reset_mid();
        a_cyc = 3'b001; a_stb = 3'b001; ack_i = 1'b0;
        a_adr = {32'h3, 32'h2, 32'h1};
        sample();
        advance();
        ack_i = 1'b1;
        sample();
        cmps++;
        if (A_ACK_O !== 3'b001) begin errs++; $display("FAIL rstmid_pre: got %b expected 001", A_ACK_O); end
        advance();
        #2;
        nRST = 1'b0;
        #1;
        model_reset();
        cmps++;
        if ({GNT_O, CYC_O, STB_O, A_ACK_O, A_ERR_O, ADR_O, A_DAT_O} !== '0) begin
            errs++; $display("FAIL rstmid_async: got gnt %b cyc %b stb %b ack %b err %b adr %h expected 0",
                             GNT_O, CYC_O, STB_O, A_ACK_O, A_ERR_O, ADR_O);
        end
        a_cyc = '0; a_stb = '0; ack_i = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        a_cyc = 3'b010; a_stb = 3'b010;
        sample();
        cmps++;
        if (GNT_O !== 3'b000) begin errs++; $display("FAIL rstmid_idle: got %b expected 000", GNT_O); end
        advance();
        sample();
        cmps++;
        if (GNT_O !== 3'b010) begin errs++; $display("FAIL rstmid_gnt: got %b expected 010", GNT_O); end
        advance();
        idle_all();
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_alternation();
        test_burst();
        test_read();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
